score_display: RTL

- Consumes the 16-bit game score from the game/block controller and shows it on the board's 4-digit, common-anode seven-segment display.
- Contains an iterative binary-to-BCD converter (shift-add-3) running continuously.
- Contains a free-running refresh counter that time-multiplexes the four digits.
- Sits directly downstream of the controller; purely a display consumer, no feedback into game logic.

---
 rtl/score_display.sv | 126 ++++++++++++
 1 files changed

// File: rtl/score_display.sv
// Four-digit seven-segment score display: continuous shift-add-3 binary-to-BCD
// conversion feeding a time-multiplexed, registered digit scan.
module score_display #(
  parameter int unsigned REFRESH_BITS  = 18,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  ssd,
  output logic        dp,
  output logic [15:0] bcd
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                  state, state_next;
  logic [13:0]             bin;
  logic [13:0]             sat;
  logic [15:0]             bcd_work, bcd_adj;
  logic [3:0]              count;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    lead_zero, lit;
  logic [3:0]              an_next;
  logic [6:0]              ssd_next, seg;

  assign dp  = 1'b1;
  assign sat = (score > 16'd9999) ? 14'd9999 : score[13:0];
  assign sel = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (count == 4'd13) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-nibble add-3 with no carry between nibbles.
  always_comb begin
    bcd_adj = bcd_work;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      bin      <= '0;
      bcd_work <= '0;
      bcd      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          bin      <= sat;
          bcd_work <= '0;
          count    <= '0;
        end
        SHIFT: begin
          {bcd_work, bin} <= {bcd_adj, bin} << 1;
          count           <= count + 4'd1;
        end
        LOAD:    bcd <= bcd_work;
        default: ;
      endcase
    end
  end

  always_comb begin
    digit     = bcd[3:0];
    lead_zero = 1'b0;
    case (sel)
      2'd0: digit = bcd[3:0];
      2'd1: begin digit = bcd[7:4];   lead_zero = (bcd[15:4]  == 12'd0); end
      2'd2: begin digit = bcd[11:8];  lead_zero = (bcd[15:8]  == 8'd0);  end
      2'd3: begin digit = bcd[15:12]; lead_zero = (bcd[15:12] == 4'd0);  end
      default: ;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  always_comb begin
    lit      = !blank && !(BLANK_LEADING && lead_zero);
    an_next  = lit ? ~(4'b0001 << sel) : 4'b1111;
    ssd_next = lit ? seg : 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh <= '0;
      an      <= '1;
      ssd     <= '1;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      an      <= an_next;
      ssd     <= ssd_next;
    end
  end

endmodule
